// File: rtl/adder_arb_pkg.sv
// ---------------------------------------------------------------------------
// adder_arb_pkg
// Shared constants for the round-robin adder arbiter:
//   N_REQ / W          - default requester count and operand width
//   ST_*               - FSM state encoding (IDLE=0, CALC=1, RESP=2)
//   N_BLK, blk_w/blk_lo - carry-select block partition (3,3,4,5,6,7 = 28 bits)
//   rsp_t              - response record {id, sum}
// ---------------------------------------------------------------------------
package adder_arb_pkg;

   localparam int N_REQ = 4;
   localparam int W     = 28;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Square-root carry-select: block widths grow toward the MSB so each
   // block's local ripple finishes about when its select carry arrives.
   localparam int N_BLK = 6;

   function automatic int blk_w(input int i);
      case (i)
         0:       return 3;
         1:       return 3;
         2:       return 4;
         3:       return 5;
         4:       return 6;
         default: return 7;
      endcase
   endfunction

   function automatic int blk_lo(input int i);
      int lo;
      lo = 0;
      for (int k = 0; k < i; k++) lo += blk_w(k);
      return lo;
   endfunction

   typedef struct packed {
      logic [1:0] id;
      logic [W:0] sum;
   } rsp_t;

endpackage

// File: rtl/add28_core.sv
// ---------------------------------------------------------------------------
// add28_core
// Combinational carry-select adder, sum = a + b + cin, full W+1 bit result.
//   a, b : W-bit operands
//   cin  : carry-in
//   sum  : W+1 bits, carry-out in the MSB
// ---------------------------------------------------------------------------
module add28_core #(
   parameter int W = 28
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W:0]   sum
);

   import adder_arb_pkg::*;

   // c[i] is the carry into block i
   logic [N_BLK:0] c;

   assign c[0] = cin;

   for (genvar gi = 0; gi < N_BLK; gi++) begin : g_blk
      localparam int LO = blk_lo(gi);
      localparam int BW = blk_w(gi);

      logic [BW:0] s0;
      logic [BW:0] s1;

      // Both carry-in hypotheses computed in parallel; the incoming carry
      // only drives the mux, not a ripple through the block.
      assign s0 = {1'b0, a[LO +: BW]} + {1'b0, b[LO +: BW]};
      assign s1 = s0 + {{BW{1'b0}}, 1'b1};

      assign sum[LO +: BW] = c[gi] ? s1[BW-1:0] : s0[BW-1:0];
      assign c[gi+1]       = c[gi] ? s1[BW]     : s0[BW];
   end

   assign sum[W] = c[N_BLK];

endmodule

// File: rtl/adder_arbiter_rr.sv
// ---------------------------------------------------------------------------
// adder_arbiter_rr
// Round-robin arbiter feeding a single registered adder, one op in flight.
//   clk, rstn          - clock, async active-low reset
//   req_valid/ready    - per-requester request / one-hot accept strobe
//   req_a, req_b       - packed operands, requester i at [i*W +: W]
//   req_cin            - per-requester carry-in
//   rsp_valid/ready    - result handshake
//   rsp_sum, rsp_id    - W+1 bit sum and owning requester
//   busy               - FSM not in IDLE
// FSM: IDLE (grant + capture) -> CALC (register sum) -> RESP (hold until taken)
// ---------------------------------------------------------------------------
module adder_arbiter_rr #(
   parameter int N_REQ = adder_arb_pkg::N_REQ,
   parameter int W     = adder_arb_pkg::W
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   input  logic [N_REQ-1:0]   req_cin,
   output logic [N_REQ-1:0]   req_ready,
   output logic               rsp_valid,
   output logic [W:0]         rsp_sum,
   output logic [1:0]         rsp_id,
   input  logic               rsp_ready,
   output logic               busy
);

   import adder_arb_pkg::*;

   logic [1:0]   state;
   logic [1:0]   ptr;
   logic [1:0]   own_id;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_cin;

   logic         grant_vld;
   logic [1:0]   grant_id;
   logic [1:0]   idx;
   logic [W:0]   sum_c;

   // Round-robin pick: walk from ptr downward in priority so the lowest
   // offset from ptr is the last (winning) assignment.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = ptr;
      idx       = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         idx = ptr + k[1:0];
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = idx;
         end
      end
   end

   // rstn gating keeps the strobe low while reset is held even though the
   // state is already IDLE and requests may be present.
   assign req_ready = (rstn && state == ST_IDLE && grant_vld)
                    ? (N_REQ'(1) << grant_id) : '0;
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

   add28_core #(.W(W)) u_core (
      .a   (op_a),
      .b   (op_b),
      .cin (op_cin),
      .sum (sum_c)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         own_id  <= '0;
         op_a    <= '0;
         op_b    <= '0;
         op_cin  <= 1'b0;
         rsp_sum <= '0;
         rsp_id  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_vld) begin
                  op_a   <= req_a[grant_id*W +: W];
                  op_b   <= req_b[grant_id*W +: W];
                  op_cin <= req_cin[grant_id];
                  own_id <= grant_id;
                  ptr    <= grant_id + 2'd1;
                  state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               rsp_sum <= sum_c;
               rsp_id  <= own_id;
               state   <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter_rr
// Directed vectors plus a random phase; expected {id,sum} records are queued
// at each grant and a separate monitor pops them on every accepted response.
// ---------------------------------------------------------------------------
module tb_adder_arbiter_rr;

   import adder_arb_pkg::*;

   localparam int NR = 4;
   localparam int WD = 28;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NR-1:0]     req_valid;
   logic [NR*WD-1:0]  req_a;
   logic [NR*WD-1:0]  req_b;
   logic [NR-1:0]     req_cin;
   logic [NR-1:0]     req_ready;
   logic              rsp_valid;
   logic [WD:0]       rsp_sum;
   logic [1:0]        rsp_id;
   logic              rsp_ready;
   logic              busy;

   logic [WD-1:0]     opa [NR];
   logic [WD-1:0]     opb [NR];

   rsp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   adder_arbiter_rr #(.N_REQ(NR), .W(WD)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NR; i++) begin
         req_a[i*WD +: WD] = opa[i];
         req_b[i*WD +: WD] = opb[i];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input logic [WD:0] sum);
      rsp_t e;
      e.id  = 2'(id);
      e.sum = sum;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(output logic [NR-1:0] rr);
      rr = '0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (|req_ready) begin
            rr = req_ready;
            return;
         end
      end
      chk("grant_timeout", 32'd1, 32'd0);
   endtask

   function automatic int pick(input logic [NR-1:0] m, input int p);
      for (int k = 0; k < NR; k++)
         if (m[(p + k) % NR]) return (p + k) % NR;
      return -1;
   endfunction

   // Scoreboard monitor: every accepted response must match the oldest grant.
   always @(negedge clk) begin : mon
      rsp_t e;
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NR-1:0] rr;
      logic [WD:0]   exp_sum [NR];
      int            ord [5];
      int            last;
      int            mptr;
      int            g;
      int            t;

      exp_sum = '{29'd9, 29'h1CF1356, 29'h1FFFFFFF, 29'h10000000};
      ord     = '{0, 1, 2, 3, 0};

      req_valid = '0;
      rsp_ready = 1'b1;
      opa[0] = 28'h0000005;  opb[0] = 28'h0000003;  req_cin = 4'b0101;
      opa[1] = 28'h1234567;  opb[1] = 28'h0ABCDEF;
      opa[2] = 28'hFFFFFFF;  opb[2] = 28'hFFFFFFF;
      opa[3] = 28'h8000000;  opb[3] = 28'h8000000;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // single request, latency
      req_valid = 4'b0001;
      wait_grant(rr);
      chk("single_grant", 32'(rr), 32'h1);
      push(0, 29'd9);
      @(posedge clk); #1;
      req_valid = '0;
      chk("calc_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("calc_busy", 32'(busy), 32'd1);
      chk("calc_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy), 32'd0);

      // overflow on requester 2 (ptr now 1)
      req_valid = 4'b0100;
      wait_grant(rr);
      chk("ovf_grant", 32'(rr), 32'h4);
      push(2, 29'h1FFFFFFF);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;

      // backpressure (ptr now 3; only requester 1 valid)
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      wait_grant(rr);
      chk("bp_grant", 32'(rr), 32'h2);
      push(1, 29'h1CF1356);
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp_sum", 32'(rsp_sum), 32'h1CF1356);
         chk("bp_rsp_id", 32'(rsp_id), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      // valid held through RESP re-requests in IDLE; ptr is 2
      wait_grant(rr);
      chk("held_grant", 32'(rr), 32'h4);
      push(2, 29'h1FFFFFFF);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;

      // reset mid-CALC (ptr 3 -> requester 0 granted, then discarded)
      req_valid = 4'b0001;
      wait_grant(rr);
      chk("pre_rst_grant", 32'(rr), 32'h1);
      @(posedge clk); #1;
      req_valid = 4'b1010;
      rstn = 1'b0;
      #1;
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rsp_sum", 32'(rsp_sum), 32'd0);
      chk("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      wait_grant(rr);
      chk("post_rst_grant", 32'(rr), 32'h2);
      push(1, 29'h1CF1356);
      @(posedge clk); #1;
      req_valid = 4'b1000;
      wait_grant(rr);
      chk("post_rst_grant2", 32'(rr), 32'h8);
      push(3, 29'h10000000);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;

      // all requesters held valid: 0,1,2,3,0 three cycles apart
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      req_valid = 4'b1111;
      last = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(rr);
         chk($sformatf("rr_order_%0d", k), 32'(rr), 32'(1 << ord[k]));
         if (k > 0) chk("rr_gap", 32'(cyc - last), 32'd3);
         last = cyc;
         push(ord[k], exp_sum[ord[k]]);
         @(posedge clk); #1;
      end
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;

      // random phase against a reference sum and round-robin model
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      mptr = 0;
      for (int op = 0; op < 10000; op++) begin
         for (int i = 0; i < NR; i++) begin
            opa[i]     = 28'($urandom);
            opb[i]     = 28'($urandom);
            req_cin[i] = 1'($urandom_range(0, 1));
         end
         req_valid = 4'($urandom_range(1, 15));
         g = pick(req_valid, mptr);
         rr = '0;
         t = 0;
         while (t < 64) begin
            @(negedge clk);
            if (|req_ready) begin
               rr = req_ready;
               break;
            end
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
            t++;
         end
         chk("rnd_grant", 32'(rr), 32'(1 << g));
         push(g, {1'b0, opa[g]} + {1'b0, opb[g]} + {{WD{1'b0}}, req_cin[g]});
         mptr = (g + 1) % NR;
         @(posedge clk); #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      chk("drain_queue", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
